// File: rtl/priority_arbiter_8.sv
// priority_arbiter_8: 8-way sequential arbiter sharing one resource.
// Two selection modes: fixed priority, where the highest index wins, and
// round-robin, which searches downward from ptr and wraps. A grant is held
// until it is released, the holder drops its request, MAX_HOLD cycles elapse,
// or en falls.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   en        enable; 0 blocks new grants and aborts an active grant
//   req[7:0]  request vector
//   rel       holder finished, honoured only while busy (the name "release"
//             is a reserved word in the language)
//   rr_mode   0 = fixed priority, 1 = round-robin; sampled at arbitration
//   gnt[7:0]  one-hot grant (registered)
//   gnt_idx   binary index of the holder, 0 when idle (registered)
//   gnt_valid grant held (registered)
//   timeout   1-cycle pulse after a MAX_HOLD revoke (registered)
module priority_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       rel,
  input  logic       rr_mode,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned N    = 8;
  localparam int unsigned IDXW = 3;
  localparam int unsigned CNTW = 8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state;
  logic [CNTW-1:0]   hold_cnt;
  logic [IDXW-1:0]   ptr;
  logic [IDXW-1:0]   win_idx;
  logic              win_found;
  logic [IDXW-1:0]   cand;

  // Winner search. In round-robin mode the search runs ptr, ptr-1, ... and
  // wraps through the 3-bit index. In fixed mode it runs 7 down to 0.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = rr_mode ? IDXW'(ptr - IDXW'(k)) : IDXW'(N - 1 - k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      ptr       <= IDXW'(N - 1);
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          // The IDLE cycle itself is the mandatory dead gap after any grant.
          if (en && win_found) begin
            state     <= BUSY;
            hold_cnt  <= '0;
            gnt       <= N'(1) << win_idx;
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (!en) begin
            // Abort: ptr is left unchanged and no timeout is raised.
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
          end else if (rel || !req[gnt_idx]) begin
            state     <= IDLE;
            ptr       <= gnt_idx - IDXW'(1);
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
          end else if (hold_cnt == CNTW'(MAX_HOLD - 1)) begin
            state     <= IDLE;
            ptr       <= gnt_idx - IDXW'(1);
            timeout   <= 1'b1;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + CNTW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_arbiter_8.sv
// Randomized and directed bench for priority_arbiter_8. A behavioural model
// tracks the holder, the number of cycles it has held the grant, and the
// round-robin pointer. The model is compared with the DUT after every edge.
module tb_priority_arbiter_8;

  localparam int unsigned MH = 4;

  logic       clk = 1'b0;
  logic       rst, en, rel, rr_mode;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid, timeout;

  int tests = 0;
  int fails = 0;

  // Model state
  bit m_busy = 0;
  int m_holder = 0;
  int m_held = 0;
  int m_ptr = 7;
  bit m_to = 0;

  int seq[$];
  bit prev_v = 0;

  priority_arbiter_8 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .rel(rel), .rr_mode(rr_mode),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input bit rr, input int p);
    int i;
    for (int k = 0; k < 8; k++) begin
      i = rr ? (p - k + 8) % 8 : 7 - k;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Model update at each edge, then comparison 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 0; m_holder = 0; m_held = 0; m_ptr = 7; m_to = 0;
      end else begin
        m_to = 0;
        if (!m_busy) begin
          if (en && req != 8'h00) begin
            m_holder = pick(req, rr_mode, m_ptr);
            m_busy = 1;
            m_held = 1;
          end
        end else if (!en) begin
          m_busy = 0;
        end else if (rel || !req[m_holder]) begin
          m_busy = 0;
          m_ptr = (m_holder + 7) % 8;
        end else if (m_held == MH) begin
          m_busy = 0;
          m_to = 1;
          m_ptr = (m_holder + 7) % 8;
        end else begin
          m_held++;
        end
      end
      #1;
      chk("gnt", 32'(gnt), m_busy ? 32'(1 << m_holder) : 32'h0);
      chk("gnt_idx", 32'(gnt_idx), m_busy ? 32'(m_holder) : 32'h0);
      chk("gnt_valid", 32'(gnt_valid), 32'(m_busy));
      chk("timeout", 32'(timeout), 32'(m_to));
      if (gnt_valid === 1'b1 && !prev_v) seq.push_back(int'(gnt_idx));
      prev_v = (gnt_valid === 1'b1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int e3[9];
    int e3b[4];
    logic [7:0] e4g[6];
    logic       e4t[6];
    e3  = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    e3b = '{5, 2, 5, 2};
    e4g = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01};
    e4t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rst = 1'b1; en = 1'b0; req = 8'h00; rel = 1'b0; rr_mode = 1'b0;

    // 1: idle with no requests
    step(2);
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t1_gnt", 32'(gnt), 32'h0);
      chk("t1_valid", 32'(gnt_valid), 32'h0);
      chk("t1_timeout", 32'(timeout), 32'h0);
    end

    // 2: fixed priority, release every grant
    seq.delete();
    rr_mode = 1'b0; req = 8'h24; rel = 1'b1;
    step(20);
    chk("t2_count", 32'(seq.size() >= 5), 32'h1);
    foreach (seq[i]) chk("t2_idx", 32'(seq[i]), 32'd5);
    req = 8'h00; rel = 1'b0;
    step(2);

    // 3: round-robin sequences
    rst = 1'b1; step(1); rst = 1'b0;
    seq.delete();
    rr_mode = 1'b1; req = 8'hFF; rel = 1'b1;
    step(18);
    chk("t3_count", 32'(seq.size() >= 9), 32'h1);
    for (int i = 0; i < 9; i++)
      if (i < seq.size()) chk("t3_idx", 32'(seq[i]), 32'(e3[i]));
    req = 8'h00; rel = 1'b0;
    rst = 1'b1; step(1); rst = 1'b0;
    seq.delete();
    req = 8'h24; rel = 1'b1;
    step(8);
    chk("t3b_count", 32'(seq.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++)
      if (i < seq.size()) chk("t3b_idx", 32'(seq[i]), 32'(e3b[i]));

    // 4: hold limit and timeout pulse
    req = 8'h00; rel = 1'b0; rr_mode = 1'b0;
    rst = 1'b1; step(1); rst = 1'b0;
    req = 8'h01;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("t4_gnt", 32'(gnt), 32'(e4g[i]));
      chk("t4_timeout", 32'(timeout), 32'(e4t[i]));
    end

    // 5: abort via en, pointer kept
    req = 8'h00;
    rst = 1'b1; step(1); rst = 1'b0;
    en = 1'b1; rr_mode = 1'b1; req = 8'h40; rel = 1'b1;
    step(1); chk("t5_gnt6", 32'(gnt), 32'h40);
    step(1); chk("t5_gap", 32'(gnt), 32'h0);
    req = 8'hFF; rel = 1'b0;
    step(1); chk("t5_idx5", 32'(gnt_idx), 32'd5); chk("t5_gnt5", 32'(gnt), 32'h20);
    en = 1'b0;
    step(1); chk("t5_abort_gnt", 32'(gnt), 32'h0); chk("t5_abort_to", 32'(timeout), 32'h0);
    step(3); chk("t5_blocked", 32'(gnt), 32'h0);
    en = 1'b1;
    step(1); chk("t5_regrant", 32'(gnt_idx), 32'd5);

    // 6: reset in the middle of a grant
    req = 8'h00;
    rst = 1'b1; step(1); rst = 1'b0;
    rr_mode = 1'b1; req = 8'h08; rel = 1'b0;
    step(1); chk("t6_idx3", 32'(gnt_idx), 32'd3);
    step(1);
    rst = 1'b1;
    step(1);
    chk("t6_gnt", 32'(gnt), 32'h0); chk("t6_idx", 32'(gnt_idx), 32'h0);
    chk("t6_valid", 32'(gnt_valid), 32'h0); chk("t6_to", 32'(timeout), 32'h0);
    rst = 1'b0; req = 8'hFF;
    step(1); chk("t6_first", 32'(gnt_idx), 32'd7);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      step(1);
      if ($urandom % 8 == 0) req = 8'($urandom);
      rel = ($urandom % 6 == 0);
      en = ($urandom % 16 != 0);
      if ($urandom % 32 == 0) rr_mode = ~rr_mode;
      rst = ($urandom % 200 == 0);
    end
    rst = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
